// File: rtl/mul_sequencer_pkg.sv
// Shared ALU control codes and the multiply sequencer state encoding.
// Also imported by the ALU control decoder and the ALU.
package mul_sequencer_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_sequencer.sv
// EX-stage multi-cycle multiply: radix-2 shift-add with a pipeline stall request.
// Handshake: stall_o holds the mul in EX; done_o marks the single cycle where result_o is valid.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output mul_state_e       dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);

  mul_state_e       r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_count;

  logic             w_start;
  logic [WIDTH-1:0] w_mplier_next;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  assign w_start       = valid_i && (ALUCtrl_i == ALU_MUL) && !flush_i && (r_state == MUL_IDLE);
  assign w_mplier_next = r_mplier >> 1;
  assign w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  // Early exit ends the iteration once no multiplier bits remain to add.
  assign w_last        = (r_count == CW'(WIDTH - 1)) ||
                         ((EARLY_EXIT != 0) && (w_mplier_next == '0));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= MUL_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_state <= MUL_IDLE;
    end else begin
      case (r_state)
        MUL_IDLE: begin
          if (w_start) begin
            r_mcand  <= data1_i;
            r_mplier <= data2_i;
            r_acc    <= '0;
            r_count  <= '0;
            r_state  <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_next;
          r_count  <= r_count + CW'(1);
          if (w_last) r_state <= MUL_DONE;
        end
        MUL_DONE: r_state <= MUL_IDLE;
        default:  r_state <= MUL_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_o  = 1'b0;
    done_o   = 1'b0;
    result_o = r_acc;
    if (rst_i) begin
      result_o = '0;
    end else if (!flush_i) begin
      case (r_state)
        MUL_IDLE: stall_o = w_start;
        MUL_BUSY: stall_o = 1'b1;
        MUL_DONE: done_o  = 1'b1;
        default:  stall_o = 1'b0;
      endcase
    end
  end

  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: one instance per EARLY_EXIT setting, directed table,
// hand-written flush/reset sequences and randomized muls against an arithmetic model.
module tb_mul_sequencer;
  import mul_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  valid;
  logic [1:0]  flush;
  logic [2:0]  ctrl [2];
  logic [31:0] d1 [2];
  logic [31:0] d2 [2];

  logic        stall0, stall1, done0, done1;
  logic [31:0] res0, res1;
  mul_state_e  st0, st1;

  mul_sequencer #(.WIDTH(32), .EARLY_EXIT(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid[0]), .ALUCtrl_i(ctrl[0]), .flush_i(flush[0]),
    .data1_i(d1[0]), .data2_i(d2[0]), .stall_o(stall0), .done_o(done0), .result_o(res0),
    .dbg_state_o(st0)
  );

  mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid[1]), .ALUCtrl_i(ctrl[1]), .flush_i(flush[1]),
    .data1_i(d1[1]), .data2_i(d2[1]), .stall_o(stall1), .done_o(done1), .result_o(res1),
    .dbg_state_o(st1)
  );

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    int          k;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_stall;
    logic        exp_done;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic drive(input int k, input logic v, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    valid[k] = v;
    ctrl[k]  = op;
    d1[k]    = a;
    d2[k]    = b;
  endtask

  task automatic sample(input int k, output logic s, output logic d, output logic [31:0] r,
                        output mul_state_e st);
    if (k == 0) begin s = stall0; d = done0; r = res0; st = st0; end
    else        begin s = stall1; d = done1; r = res1; st = st1; end
  endtask

  // Reference: product low half by plain arithmetic; busy cycles from multiplier bit length.
  function automatic int model_busy(input int k, input logic [31:0] b);
    int n;
    if (k == 0) return 32;
    n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  // One instruction in EX: stays while stalled, leaves after the first unstalled cycle.
  task automatic exec(input int k, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input bit scramble,
                      output int n_stall, output bit got_done, output logic [31:0] got_res);
    logic s, d;
    logic [31:0] r;
    mul_state_e st;
    bit left;
    left = 0;
    n_stall = 0;
    got_done = 0;
    got_res = '0;
    drive(k, 1'b1, op, a, b);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      sample(k, s, d, r, st);
      if (d) begin got_done = 1; got_res = r; end
      if (!s) begin left = 1; break; end
      n_stall++;
      @(posedge clk); #1;
      if (scramble) drive(k, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
    end
    if (!left) chk("exec_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    valid[k] = 1'b0;
  endtask

  initial begin
    int ns;
    bit gd;
    logic [31:0] gr;
    logic s, d;
    logic [31:0] r;
    mul_state_e st;

    valid = '0;
    flush = '0;
    for (int k = 0; k < 2; k++) drive(k, 1'b0, ALU_ADD, '0, '0);

    vecs[0]  = '{1, ALU_MUL, 32'd3,          32'd5,          4,  1'b1, 32'd15};
    vecs[1]  = '{1, ALU_MUL, 32'd3,          32'd0,          2,  1'b1, 32'd0};
    vecs[2]  = '{0, ALU_MUL, 32'd7,          32'd6,          33, 1'b1, 32'd42};
    vecs[3]  = '{1, ALU_MUL, 32'hFFFFFFFF,   32'd5,          4,  1'b1, 32'hFFFFFFFB};
    vecs[4]  = '{0, ALU_MUL, 32'hFFFFFFFF,   32'd5,          33, 1'b1, 32'hFFFFFFFB};
    vecs[5]  = '{1, ALU_MUL, 32'h80000000,   32'd2,          3,  1'b1, 32'd0};
    vecs[6]  = '{0, ALU_MUL, 32'h80000000,   32'd2,          33, 1'b1, 32'd0};
    vecs[7]  = '{1, ALU_MUL, 32'd4,          32'd4,          4,  1'b1, 32'd16};
    vecs[8]  = '{1, ALU_MUL, 32'd2,          32'd9,          5,  1'b1, 32'd18};
    vecs[9]  = '{1, ALU_ADD, 32'd5,          32'd6,          0,  1'b0, 32'd0};
    vecs[10] = '{0, ALU_ADD, 32'd5,          32'd6,          0,  1'b0, 32'd0};
    vecs[11] = '{1, ALU_MUL, 32'hFFFFFFFE,   32'hFFFFFFFD,   33, 1'b1, 32'd6};

    // Reset with a mul held on the early-exit instance.
    drive(1, 1'b1, ALU_MUL, 32'd3, 32'd5);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        sample(k, s, d, r, st);
        chk("reset_stall", 32'(s), 32'd0);
        chk("reset_done", 32'(d), 32'd0);
        chk("reset_result", r, 32'd0);
      end
    end
    chk("reset_state", 32'(st1), 32'(MUL_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table, applied back to back with no bubbles.
    for (int i = 0; i < 12; i++) begin
      exec(vecs[i].k, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, ns, gd, gr);
      chk($sformatf("vec%0d_stall", i), 32'(ns), 32'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_done", i), 32'(gd), 32'(vecs[i].exp_done));
      if (vecs[i].exp_done) chk($sformatf("vec%0d_result", i), gr, vecs[i].exp_res);
    end

    // Flush in the 5th busy cycle.
    drive(0, 1'b1, ALU_MUL, 32'd7, 32'd6);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("flush_pre_stall", 32'(stall0), 32'd1);
      @(posedge clk); #1;
    end
    flush[0] = 1'b1;
    @(negedge clk);
    chk("flush_stall", 32'(stall0), 32'd0);
    chk("flush_done", 32'(done0), 32'd0);
    @(posedge clk); #1;
    flush[0] = 1'b0;
    valid[0] = 1'b0;
    @(negedge clk);
    chk("flush_idle", 32'(st0), 32'(MUL_IDLE));
    chk("flush_idle_stall", 32'(stall0), 32'd0);
    @(posedge clk); #1;

    // Flush together with a would-be start.
    drive(1, 1'b1, ALU_MUL, 32'd9, 32'd9);
    flush[1] = 1'b1;
    @(negedge clk);
    chk("flush_start_stall", 32'(stall1), 32'd0);
    @(posedge clk); #1;
    flush[1] = 1'b0;
    valid[1] = 1'b0;
    @(negedge clk);
    chk("flush_start_idle", 32'(st1), 32'(MUL_IDLE));
    @(posedge clk); #1;

    // Reset in the middle of a long multiply.
    drive(1, 1'b1, ALU_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_stall", 32'(stall1), 32'd0);
    chk("midreset_done", 32'(done1), 32'd0);
    chk("midreset_result", res1, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    valid[1] = 1'b0;
    @(negedge clk);
    chk("midreset_idle", 32'(st1), 32'(MUL_IDLE));
    @(posedge clk); #1;

    // Randomized traffic with input scrambling while the mul is held.
    for (int i = 0; i < 40; i++) begin
      int k;
      bit is_mul;
      logic [2:0] op;
      logic [31:0] a, b;
      k = $urandom_range(0, 1);
      is_mul = ($urandom_range(0, 3) != 0);
      op = is_mul ? ALU_MUL : 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (is_mul) exp_q.push_back(a * b);
      exec(k, op, a, b, 1'b1, ns, gd, gr);
      if (is_mul) begin
        chk($sformatf("rnd%0d_stall", i), 32'(ns), 32'(model_busy(k, b) + 1));
        chk($sformatf("rnd%0d_done", i), 32'(gd), 32'd1);
        if (exp_q.size() > 0) chk($sformatf("rnd%0d_result", i), gr, exp_q.pop_front());
      end else begin
        chk($sformatf("rnd%0d_nomul_stall", i), 32'(ns), 32'd0);
        chk($sformatf("rnd%0d_nomul_done", i), 32'(gd), 32'd0);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
